// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: response routing tags,
// grant encoding and the log2 helper used to size counters.
package mem_arb_pkg;

   localparam logic TAG_I = 1'b0;
   localparam logic TAG_D = 1'b1;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_e;

   // Ceiling log2, valid for value >= 1.
   function automatic int log2(input int value);
      int result;
      result = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) result = i + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/mem_arb_tag_fifo.sv
// In-order tag FIFO remembering which requester owns each outstanding read.
// Pushes while full and pops while empty are ignored.
module mem_arb_tag_fifo
   import mem_arb_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PTR_W = log2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             push,
   input  logic             push_tag,
   input  logic             pop,
   output logic             head_tag,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count
);

   logic [DEPTH-1:0] slot_q, slot_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign head_tag = slot_q[rd_ptr_q];
   assign do_push  = push & ~full;
   assign do_pop   = pop & ~empty;

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_comb begin
      slot_d   = slot_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         slot_d[wr_ptr_q] = push_tag;
         wr_ptr_d         = wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         slot_q   <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         slot_q   <= slot_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data ports onto one memory port and routes in-order
// read responses back. Define MEM_ARB_ROUND_ROBIN_EN for round-robin grant.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int CORE            = 0,
   parameter int DATA_WIDTH      = 32,
   parameter int ADDRESS_BITS    = 20,
   parameter int MAX_OUTSTANDING = 4,
   localparam int BE_W  = DATA_WIDTH / 8,
   localparam int CNT_W = log2(MAX_OUTSTANDING) + 1
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    i_req_read,
   input  logic [ADDRESS_BITS-1:0] i_req_address,
   output logic                    i_req_ready,
   output logic                    i_resp_valid,
   output logic [DATA_WIDTH-1:0]   i_resp_data,
   input  logic                    d_req_read,
   input  logic                    d_req_write,
   input  logic [ADDRESS_BITS-1:0] d_req_address,
   input  logic [DATA_WIDTH-1:0]   d_req_data,
   input  logic [BE_W-1:0]         d_req_byte_en,
   output logic                    d_req_ready,
   output logic                    d_resp_valid,
   output logic [DATA_WIDTH-1:0]   d_resp_data,
   output logic                    mem_read,
   output logic                    mem_write,
   output logic [ADDRESS_BITS-1:0] mem_address,
   output logic [DATA_WIDTH-1:0]   mem_data,
   output logic [BE_W-1:0]         mem_byte_en,
   input  logic                    mem_ready,
   input  logic                    mem_resp_valid,
   input  logic [DATA_WIDTH-1:0]   mem_resp_data,
   output logic                    i_mem_hazard,
   output logic                    d_mem_issue_hazard,
   output logic                    d_mem_recv_hazard,
   output logic                    protocol_error,
   input  logic                    scan
);

   logic                  tag_head, tag_full, tag_empty;
   logic [CNT_W-1:0]      tag_count;
   logic                  grant_d, grant_i, gnt_read, gnt_write, slot_ok;
   logic                  push, push_tag, pop;
   logic                  i_resp_valid_q, i_resp_valid_d;
   logic                  d_resp_valid_q, d_resp_valid_d;
   logic [DATA_WIDTH-1:0] i_resp_data_q, i_resp_data_d;
   logic [DATA_WIDTH-1:0] d_resp_data_q, d_resp_data_d;
   logic [CNT_W-1:0]      d_cnt_q, d_cnt_d;
   logic                  protocol_error_q, protocol_error_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   grant_e                prio_q, prio_d;
`endif

   mem_arb_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
      .clock    (clock),
      .reset    (reset),
      .push     (push),
      .push_tag (push_tag),
      .pop      (pop),
      .head_tag (tag_head),
      .full     (tag_full),
      .empty    (tag_empty),
      .count    (tag_count)
   );

   // A pop in the same cycle does not free a slot, so only the registered count matters.
   assign slot_ok = (tag_count < CNT_W'(MAX_OUTSTANDING));

   always_comb begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      grant_d = (d_req_read | d_req_write) & (~i_req_read | (prio_q == GRANT_D));
`else
      grant_d = d_req_read | d_req_write;
`endif
      grant_i   = ~grant_d & i_req_read;
      gnt_write = grant_d & d_req_write;
      gnt_read  = grant_d ? (d_req_read & ~d_req_write) : grant_i;

      d_req_ready = grant_d & mem_ready & (gnt_write | slot_ok);
      i_req_ready = grant_i & mem_ready & slot_ok;

      mem_read    = reset & gnt_read & slot_ok;
      mem_write   = reset & gnt_write;
      mem_address = grant_d ? d_req_address : i_req_address;
      mem_data    = d_req_data;
      mem_byte_en = gnt_write ? d_req_byte_en : {BE_W{1'b1}};

      push     = mem_ready & gnt_read & slot_ok;
      push_tag = grant_d ? TAG_D : TAG_I;
      pop      = mem_resp_valid & ~tag_empty;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      prio_d = prio_q;
      if (i_req_ready | d_req_ready) prio_d = grant_d ? GRANT_I : GRANT_D;
`endif
   end

   // Response routing, outstanding data-read tracking and sticky error.
   always_comb begin
      i_resp_valid_d   = pop & (tag_head == TAG_I);
      d_resp_valid_d   = pop & (tag_head == TAG_D);
      i_resp_data_d    = i_resp_valid_d ? mem_resp_data : i_resp_data_q;
      d_resp_data_d    = d_resp_valid_d ? mem_resp_data : d_resp_data_q;
      d_cnt_d          = d_cnt_q + CNT_W'(push & grant_d) - CNT_W'(d_resp_valid_q);
      protocol_error_d = protocol_error_q
                       | (d_req_read & d_req_write)
                       | (mem_resp_valid & tag_empty);
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         i_resp_valid_q   <= 1'b0;
         d_resp_valid_q   <= 1'b0;
         i_resp_data_q    <= '0;
         d_resp_data_q    <= '0;
         d_cnt_q          <= '0;
         protocol_error_q <= 1'b0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         prio_q           <= GRANT_D;
`endif
      end else begin
         i_resp_valid_q   <= i_resp_valid_d;
         d_resp_valid_q   <= d_resp_valid_d;
         i_resp_data_q    <= i_resp_data_d;
         d_resp_data_q    <= d_resp_data_d;
         d_cnt_q          <= d_cnt_d;
         protocol_error_q <= protocol_error_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         prio_q           <= prio_d;
`endif
      end
   end

   assign i_resp_valid       = i_resp_valid_q;
   assign i_resp_data        = i_resp_data_q;
   assign d_resp_valid       = d_resp_valid_q;
   assign d_resp_data        = d_resp_data_q;
   assign protocol_error     = protocol_error_q;
   assign d_mem_recv_hazard  = (d_cnt_q != '0);
   assign i_mem_hazard       = i_req_read & ~i_req_ready;
   assign d_mem_issue_hazard = (d_req_read | d_req_write) & ~d_req_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; the round-robin grant
// check runs when MEM_ARB_ROUND_ROBIN_EN is defined, fixed priority otherwise.
module tb_mem_port_arbiter;

   logic        clock = 1'b0;
   logic        reset;
   logic        i_req_read;
   logic [19:0] i_req_address;
   logic        i_req_ready, i_resp_valid;
   logic [31:0] i_resp_data;
   logic        d_req_read, d_req_write;
   logic [19:0] d_req_address;
   logic [31:0] d_req_data;
   logic [3:0]  d_req_byte_en;
   logic        d_req_ready, d_resp_valid;
   logic [31:0] d_resp_data;
   logic        mem_read, mem_write;
   logic [19:0] mem_address;
   logic [31:0] mem_data;
   logic [3:0]  mem_byte_en;
   logic        mem_ready, mem_resp_valid;
   logic [31:0] mem_resp_data;
   logic        i_mem_hazard, d_mem_issue_hazard, d_mem_recv_hazard;
   logic        protocol_error;
   logic        scan;

   int n_compared   = 0;
   int n_mismatched = 0;

   mem_port_arbiter #(
      .CORE(0), .DATA_WIDTH(32), .ADDRESS_BITS(20), .MAX_OUTSTANDING(4)
   ) dut (
      .clock              (clock),
      .reset              (reset),
      .i_req_read         (i_req_read),
      .i_req_address      (i_req_address),
      .i_req_ready        (i_req_ready),
      .i_resp_valid       (i_resp_valid),
      .i_resp_data        (i_resp_data),
      .d_req_read         (d_req_read),
      .d_req_write        (d_req_write),
      .d_req_address      (d_req_address),
      .d_req_data         (d_req_data),
      .d_req_byte_en      (d_req_byte_en),
      .d_req_ready        (d_req_ready),
      .d_resp_valid       (d_resp_valid),
      .d_resp_data        (d_resp_data),
      .mem_read           (mem_read),
      .mem_write          (mem_write),
      .mem_address        (mem_address),
      .mem_data           (mem_data),
      .mem_byte_en        (mem_byte_en),
      .mem_ready          (mem_ready),
      .mem_resp_valid     (mem_resp_valid),
      .mem_resp_data      (mem_resp_data),
      .i_mem_hazard       (i_mem_hazard),
      .d_mem_issue_hazard (d_mem_issue_hazard),
      .d_mem_recv_hazard  (d_mem_recv_hazard),
      .protocol_error     (protocol_error),
      .scan               (scan)
   );

   always #5 clock = ~clock;

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      n_compared++;
      assert (observed === expected) else begin
         n_mismatched++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   initial begin
      reset = 1'b0; scan = 1'b0;
      i_req_read = 1'b0; i_req_address = '0;
      d_req_read = 1'b0; d_req_write = 1'b0; d_req_address = '0;
      d_req_data = '0; d_req_byte_en = '0;
      mem_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;

      // Reset state; a pending fetch must not reach the memory while in reset.
      repeat (2) @(negedge clock);
      i_req_read = 1'b1; i_req_address = 20'h10; mem_ready = 1'b1; #1;
      check_output("rst_mem_read", mem_read, 0);
      check_output("rst_i_resp_valid", i_resp_valid, 0);
      check_output("rst_d_resp_valid", d_resp_valid, 0);
      check_output("rst_i_resp_data", i_resp_data, 0);
      check_output("rst_d_resp_data", d_resp_data, 0);
      check_output("rst_protocol_error", protocol_error, 0);
      check_output("rst_recv_hazard", d_mem_recv_hazard, 0);
      i_req_read = 1'b0; mem_ready = 1'b0;
      @(negedge clock); reset = 1'b1;

      // Single fetch read, first with memory stalling.
      @(negedge clock);
      i_req_read = 1'b1; i_req_address = 20'h10; mem_ready = 1'b0; #1;
      check_output("fetch_stall_ready", i_req_ready, 0);
      check_output("fetch_stall_hazard", i_mem_hazard, 1);
      check_output("fetch_stall_mem_read", mem_read, 1);
      mem_ready = 1'b1; #1;
      check_output("fetch_ready", i_req_ready, 1);
      check_output("fetch_hazard", i_mem_hazard, 0);
      check_output("fetch_mem_address", mem_address, 32'h10);
      check_output("fetch_byte_en", mem_byte_en, 32'hF);
      @(negedge clock);
      i_req_read = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'hDEADBEEF; #1;
      check_output("fetch_resp_not_early", i_resp_valid, 0);
      @(negedge clock);
      mem_resp_valid = 1'b0; #1;
      check_output("fetch_resp_valid", i_resp_valid, 1);
      check_output("fetch_resp_data", i_resp_data, 32'hDEADBEEF);
      check_output("fetch_resp_not_d", d_resp_valid, 0);
      @(negedge clock); #1;
      check_output("fetch_resp_pulse_end", i_resp_valid, 0);
      check_output("fetch_resp_data_hold", i_resp_data, 32'hDEADBEEF);

`ifdef MEM_ARB_ROUND_ROBIN_EN
      // Both requesting continuously: grants alternate D, I, D, I.
      @(negedge clock);
      i_req_read = 1'b1; i_req_address = 20'h20;
      d_req_read = 1'b1; d_req_address = 20'h30;
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clock);
         #1;
         check_output("rr_d_ready", d_req_ready, (k % 2 == 0) ? 1 : 0);
         check_output("rr_i_ready", i_req_ready, (k % 2 == 0) ? 0 : 1);
      end
      @(negedge clock);
      i_req_read = 1'b0; d_req_read = 1'b0;
      for (int k = 0; k < 4; k++) begin
         mem_resp_valid = 1'b1; mem_resp_data = 32'h100 + k;
         @(negedge clock);
      end
      mem_resp_valid = 1'b0;
      repeat (2) @(negedge clock); #1;
      check_output("rr_recv_hazard_clear", d_mem_recv_hazard, 0);
`else
      // Simultaneous reads: data wins, fetch follows, responses route d then i.
      @(negedge clock);
      i_req_read = 1'b1; i_req_address = 20'h20;
      d_req_read = 1'b1; d_req_address = 20'h30; #1;
      check_output("prio_d_ready", d_req_ready, 1);
      check_output("prio_i_ready", i_req_ready, 0);
      check_output("prio_i_hazard", i_mem_hazard, 1);
      check_output("prio_mem_address", mem_address, 32'h30);
      @(negedge clock);
      d_req_read = 1'b0; #1;
      check_output("prio_i_next", i_req_ready, 1);
      check_output("prio_mem_address2", mem_address, 32'h20);
      check_output("prio_recv_hazard", d_mem_recv_hazard, 1);
      @(negedge clock);
      i_req_read = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = 32'h11111111;
      @(negedge clock);
      mem_resp_data = 32'h22222222; #1;
      check_output("prio_d_resp_valid", d_resp_valid, 1);
      check_output("prio_d_resp_data", d_resp_data, 32'h11111111);
      check_output("prio_i_not_first", i_resp_valid, 0);
      @(negedge clock);
      mem_resp_valid = 1'b0; #1;
      check_output("prio_i_resp_valid", i_resp_valid, 1);
      check_output("prio_i_resp_data", i_resp_data, 32'h22222222);
      check_output("prio_d_pulse_end", d_resp_valid, 0);
      check_output("prio_recv_hazard_clear", d_mem_recv_hazard, 0);
`endif

      // Fill all four slots; the fifth read stalls while a write still goes through.
      for (int k = 0; k < 4; k++) begin
         @(negedge clock);
         i_req_read = 1'b1; i_req_address = 20'h40 + k; #1;
         check_output("fill_ready", i_req_ready, 1);
      end
      @(negedge clock); #1;
      check_output("full_i_ready", i_req_ready, 0);
      check_output("full_i_hazard", i_mem_hazard, 1);
      check_output("full_mem_read", mem_read, 0);
      i_req_read = 1'b0;
      d_req_write = 1'b1; d_req_address = 20'h50; d_req_data = 32'hCAFEF00D;
      d_req_byte_en = 4'b0011; #1;
      check_output("full_write_ready", d_req_ready, 1);
      check_output("full_mem_write", mem_write, 1);
      check_output("full_mem_data", mem_data, 32'hCAFEF00D);
      check_output("full_byte_en", mem_byte_en, 32'h3);
      check_output("full_issue_hazard", d_mem_issue_hazard, 0);
      @(negedge clock);
      d_req_write = 1'b0; i_req_read = 1'b1;
      mem_resp_valid = 1'b1; mem_resp_data = 32'h0A0A0A0A; #1;
      check_output("pop_same_cycle_no_slot", i_req_ready, 0);
      @(negedge clock);
      mem_resp_valid = 1'b0; #1;
      check_output("slot_freed_ready", i_req_ready, 1);
      check_output("slot_freed_resp", i_resp_valid, 1);
      check_output("slot_freed_data", i_resp_data, 32'h0A0A0A0A);
      @(negedge clock);
      i_req_read = 1'b0;
      for (int k = 0; k < 4; k++) begin
         mem_resp_valid = 1'b1; mem_resp_data = 32'h200 + k;
         @(negedge clock);
      end
      mem_resp_valid = 1'b0; #1;
      check_output("drain_last_valid", i_resp_valid, 1);
      check_output("drain_last_data", i_resp_data, 32'h203);
      check_output("drain_no_error", protocol_error, 0);

      // Response with nothing outstanding.
      @(negedge clock);
      mem_resp_valid = 1'b1; mem_resp_data = 32'h55; #1;
      check_output("orphan_error_before", protocol_error, 0);
      @(negedge clock);
      mem_resp_valid = 1'b0; #1;
      check_output("orphan_error_set", protocol_error, 1);
      check_output("orphan_no_i_valid", i_resp_valid, 0);
      check_output("orphan_no_d_valid", d_resp_valid, 0);
      check_output("orphan_i_data_hold", i_resp_data, 32'h203);
      repeat (2) @(negedge clock); #1;
      check_output("orphan_error_sticky", protocol_error, 1);

      // Reset with two data reads outstanding, then a late response.
      @(negedge clock);
      d_req_read = 1'b1; d_req_address = 20'h100;
      repeat (2) @(negedge clock);
      d_req_read = 1'b0; #1;
      check_output("pre_reset_recv_hazard", d_mem_recv_hazard, 1);
      reset = 1'b0; #1;
      check_output("async_rst_recv_hazard", d_mem_recv_hazard, 0);
      check_output("async_rst_error", protocol_error, 0);
      check_output("async_rst_d_valid", d_resp_valid, 0);
      @(negedge clock);
      reset = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = 32'h77;
      @(negedge clock);
      mem_resp_valid = 1'b0; #1;
      check_output("late_resp_error", protocol_error, 1);
      check_output("late_resp_no_valid", d_resp_valid, 0);
      check_output("late_resp_data", d_resp_data, 0);

      // Read and write together: write issues, read dropped, error flagged.
      reset = 1'b0; #1;
      @(negedge clock);
      reset = 1'b1;
      d_req_read = 1'b1; d_req_write = 1'b1; d_req_address = 20'h200;
      d_req_data = 32'h12345678; d_req_byte_en = 4'hF; mem_ready = 1'b1; #1;
      check_output("rw_ready", d_req_ready, 1);
      check_output("rw_mem_write", mem_write, 1);
      check_output("rw_mem_read", mem_read, 0);
      check_output("rw_error_before", protocol_error, 0);
      @(negedge clock);
      d_req_read = 1'b0; d_req_write = 1'b0; #1;
      check_output("rw_error_set", protocol_error, 1);
      check_output("rw_no_recv_hazard", d_mem_recv_hazard, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the core's instruction-fetch port and data port onto one shared single-ported memory interface. Read responses return in order and are routed back to their requester. The block also drives the fetch and data stall signals consumed by `control_unit`. It sits between the core's fetch/memory stages and the unified memory or cache port.

## Interface
Parameters:
- CORE, 0, core index (debug/scan messages only)
- DATA_WIDTH, 32, memory word width
- ADDRESS_BITS, 20, address width
- MAX_OUTSTANDING, 4, in-flight reads tracked (power of two, ≥2)

Ports:
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low (asserted at 0)
- i_req_read  in  1  fetch read request
- i_req_address  in  ADDRESS_BITS  fetch address
- i_req_ready  out  1  fetch request accepted this cycle
- i_resp_valid  out  1  fetch read data valid (one-cycle pulse)
- i_resp_data  out  DATA_WIDTH  fetch read data
- d_req_read  in  1  data read request
- d_req_write  in  1  data write request
- d_req_address  in  ADDRESS_BITS  data address
- d_req_data  in  DATA_WIDTH  write data
- d_req_byte_en  in  DATA_WIDTH/8  write byte enables
- d_req_ready  out  1  data request accepted this cycle
- d_resp_valid  out  1  data read data valid (one-cycle pulse)
- d_resp_data  out  DATA_WIDTH  data read data
- mem_read, mem_write  out  1  memory command
- mem_address  out  ADDRESS_BITS  memory address
- mem_data  out  DATA_WIDTH  memory write data
- mem_byte_en  out  DATA_WIDTH/8  memory byte enables (all ones on reads)
- mem_ready  in  1  memory accepts a command this cycle
- mem_resp_valid  in  1  memory read data valid, returned in issue order
- mem_resp_data  in  DATA_WIDTH  memory read data
- i_mem_hazard  out  1  = i_req_read & ~i_req_ready
- d_mem_issue_hazard  out  1  = (d_req_read|d_req_write) & ~d_req_ready
- d_mem_recv_hazard  out  1  at least one data read is outstanding or undelivered
- protocol_error  out  1  sticky error flag
- scan  in  1  prints tag FIFO and grant state when SCAN_CYCLES_MIN ≤ cycle ≤ SCAN_CYCLES_MAX (simulation only)

## Operation
- Request-to-memory path is combinational. The granted requester's fields drive the mem_* outputs. Ready for the granted requester = mem_ready & slot_ok.
- slot_ok: writes are always OK. Reads require count < MAX_OUTSTANDING. A pop in the same cycle does not free a slot.
- Accepted read: push tag into the tag FIFO (TAG_I=0, TAG_D=1). Accepted write: no tag, no response.
- d_req_read & d_req_write together: the write issues, the read is dropped, and protocol_error is set.
- mem_resp_valid: pop the head tag. Register the data into the matching resp_data and pulse the matching resp_valid the next cycle. resp_data holds its value until the next response.
- mem_resp_valid with the FIFO empty: the response is ignored, protocol_error is set, and no resp_valid is generated.
- Data-read counter: increments on push of TAG_D and decrements on delivery of a data response. d_mem_recv_hazard = (counter ≠ 0).
- protocol_error is cleared only by reset.

## Timing
- Reset (asynchronous assert): FIFO empty, counters 0, grant pointer = data, all *_resp_valid=0, *_resp_data=0, protocol_error=0.
- Combinational outputs reflect their inputs during reset; mem_read/mem_write are forced to 0 while reset=0.
- Issue latency is 0 cycles (same cycle as ready). Response latency is exactly 1 cycle after mem_resp_valid.
- Back-to-back accepts are allowed every cycle. Push and pop may occur in the same cycle when not full.
- Responses in flight across a reset arrive to an empty FIFO and set protocol_error; this is intended.

## Configuration
- MEM_ARB_ROUND_ROBIN_EN undefined: fixed priority. A data request always wins over fetch.
- MEM_ARB_ROUND_ROBIN_EN defined: when both requesters request, grant goes to the one not granted on the last accepted request. The pointer updates only on acceptance, and the reset pointer favours data.

## Structure
- Shared package mem_arb_pkg holds TAG_I, TAG_D, and the log2 function used for counter widths.
- One sub-module, mem_arb_tag_fifo: 1-bit wide, MAX_OUTSTANDING deep, with full/empty/count outputs and asynchronous active-low reset.

## Test plan
- Fetch read only, address 0x10, mem_ready=1 → i_req_ready=1 the same cycle; mem_resp_valid with data 0xDEADBEEF → i_resp_valid=1 and i_resp_data=0xDEADBEEF one cycle later.
- Simultaneous fetch and data read, fixed priority → data issues first and i_mem_hazard=1. The fetch issues next cycle. Responses route to d then i in order.
- With MEM_ARB_ROUND_ROBIN_EN and both requesting continuously for 4 cycles → grants alternate D, I, D, I.
- Issue 4 reads with no responses → the 5th read sees ready=0 and the hazard asserts. A write is still accepted. After one response, reads are accepted again.
- mem_resp_valid with no outstanding reads → protocol_error=1 and stays high; no resp_valid pulse.
- Reset asserted with 2 reads outstanding → d_mem_recv_hazard=0 and resp_valid=0 immediately. A late response after release sets protocol_error.
